// File: rtl/cache_pkg.sv
// Shared geometry, address field offsets, FSM states and block packing helpers
// for the 2-way, 2-set, 4-word write-back data cache.
package cache_pkg;
   localparam int unsigned ADDR_W  = 10;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned BLK_W   = 128;
   localparam int unsigned TAG_HI  = 9;
   localparam int unsigned TAG_LO  = 5;
   localparam int unsigned IDX     = 4;
   localparam int unsigned WORD_HI = 3;
   localparam int unsigned WORD_LO = 2;
   localparam int unsigned TAG_W   = TAG_HI - TAG_LO + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COMPARE,
      S_WRITEBACK,
      S_ALLOCATE,
      S_DONE
   } state_e;

   function automatic logic [DATA_W-1:0] blk_word(input logic [BLK_W-1:0] blk,
                                                  input logic [1:0] w);
      return blk[w*DATA_W +: DATA_W];
   endfunction

   function automatic logic [BLK_W-1:0] blk_put(input logic [BLK_W-1:0] blk,
                                                input logic [1:0] w,
                                                input logic [DATA_W-1:0] d);
      logic [BLK_W-1:0] r;
      r = blk;
      r[w*DATA_W +: DATA_W] = d;
      return r;
   endfunction

   function automatic logic [ADDR_W-1:0] blk_addr(input logic [TAG_W-1:0] tag,
                                                  input logic idx);
      return {tag, idx, 4'b0000};
   endfunction
endpackage

// File: rtl/cache_controller_store.sv
// Tag/valid/dirty/lru/data arrays: one indexed lookup, one word-write port
// (sets dirty) and one block-fill port (valid, clean, new tag).
module cache_store
   import cache_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   idx_i,
   output logic [1:0]             valid_o,
   output logic [1:0]             dirty_o,
   output logic [1:0][TAG_W-1:0]  tag_o,
   output logic [1:0][BLK_W-1:0]  blk_o,
   output logic                   lru_o,
   input  logic                   wr_en_i,
   input  logic                   wr_way_i,
   input  logic [1:0]             wr_word_i,
   input  logic [DATA_W-1:0]      wr_data_i,
   input  logic                   lru_we_i,
   input  logic                   lru_i,
   input  logic                   fill_en_i,
   input  logic                   fill_way_i,
   input  logic [TAG_W-1:0]       fill_tag_i,
   input  logic [BLK_W-1:0]       fill_blk_i
);
   logic [1:0][1:0]             valid_q;
   logic [1:0][1:0]             dirty_q;
   logic [1:0][1:0][TAG_W-1:0]  tag_q;
   logic [1:0][1:0][BLK_W-1:0]  data_q;
   logic [1:0]                  lru_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
         tag_q   <= '0;
         data_q  <= '0;
         lru_q   <= '0;
      end else begin
         if (fill_en_i) begin
            valid_q[idx_i][fill_way_i] <= 1'b1;
            dirty_q[idx_i][fill_way_i] <= 1'b0;
            tag_q[idx_i][fill_way_i]   <= fill_tag_i;
            data_q[idx_i][fill_way_i]  <= fill_blk_i;
         end else if (wr_en_i) begin
            data_q[idx_i][wr_way_i]  <= blk_put(data_q[idx_i][wr_way_i], wr_word_i, wr_data_i);
            dirty_q[idx_i][wr_way_i] <= 1'b1;
         end
         if (lru_we_i) lru_q[idx_i] <= lru_i;
      end
   end

   assign valid_o = valid_q[idx_i];
   assign dirty_o = dirty_q[idx_i];
   assign tag_o   = tag_q[idx_i];
   assign blk_o   = data_q[idx_i];
   assign lru_o   = lru_q[idx_i];
endmodule

// File: rtl/cache_controller.sv
// Clocked cache sequencer: latches a CPU request, then runs compare,
// dirty-victim write-back and refill with registered CPU and memory outputs.
module cache_controller
   import cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_rw,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic              cpu_hit,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              mem_req,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [BLK_W-1:0]  mem_wdata,
   input  logic [BLK_W-1:0]  mem_rdata,
   input  logic              mem_ready
);
   state_e              state_q;
   logic                rw_q, miss_q, victim_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                cpu_ready_q, cpu_hit_q, mem_req_q, mem_rw_q;
   logic [DATA_W-1:0]   cpu_rdata_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [BLK_W-1:0]    mem_wdata_q;

   logic [1:0]             s_valid, s_dirty;
   logic [1:0][TAG_W-1:0]  s_tag;
   logic [1:0][BLK_W-1:0]  s_blk;
   logic                   s_lru;

   logic                idx;
   logic [TAG_W-1:0]    tag;
   logic [1:0]          word;
   logic                hit0, hit1, hit, hit_way, victim_d;
   logic                unused_byte;

   assign idx         = addr_q[IDX];
   assign tag         = addr_q[TAG_HI:TAG_LO];
   assign word        = addr_q[WORD_HI:WORD_LO];
   assign unused_byte = ^addr_q[1:0];

   assign hit0    = s_valid[0] && (s_tag[0] == tag);
   assign hit1    = s_valid[1] && (s_tag[1] == tag);
   assign hit     = hit0 | hit1;
   assign hit_way = ~hit0;

   always_comb begin
      victim_d = s_lru;
      if (!s_valid[0])      victim_d = 1'b0;
      else if (!s_valid[1]) victim_d = 1'b1;
   end

   cache_store u_store (
      .clk        (clk),
      .rst        (rst),
      .idx_i      (idx),
      .valid_o    (s_valid),
      .dirty_o    (s_dirty),
      .tag_o      (s_tag),
      .blk_o      (s_blk),
      .lru_o      (s_lru),
      .wr_en_i    ((state_q == S_COMPARE) && hit && rw_q),
      .wr_way_i   (hit_way),
      .wr_word_i  (word),
      .wr_data_i  (wdata_q),
      .lru_we_i   ((state_q == S_COMPARE) && hit),
      .lru_i      (~hit_way),
      .fill_en_i  ((state_q == S_ALLOCATE) && mem_req_q && mem_ready),
      .fill_way_i (victim_q),
      .fill_tag_i (tag),
      .fill_blk_i (mem_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rw_q        <= 1'b0;
         miss_q      <= 1'b0;
         victim_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_ready_q <= 1'b0;
         cpu_hit_q   <= 1'b0;
         cpu_rdata_q <= '0;
         mem_req_q   <= 1'b0;
         mem_rw_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         cpu_ready_q <= 1'b0;
         case (state_q)
            S_IDLE: if (cpu_req) begin
               rw_q    <= cpu_rw;
               addr_q  <= cpu_addr;
               wdata_q <= cpu_wdata;
               miss_q  <= 1'b0;
               state_q <= S_COMPARE;
            end
            S_COMPARE: if (hit) begin
               if (!rw_q) cpu_rdata_q <= blk_word(s_blk[hit_way], word);
               cpu_ready_q <= 1'b1;
               cpu_hit_q   <= ~miss_q;
               state_q     <= S_DONE;
            end else begin
               miss_q    <= 1'b1;
               victim_q  <= victim_d;
               mem_req_q <= 1'b1;
               if (s_valid[victim_d] && s_dirty[victim_d]) begin
                  mem_rw_q    <= 1'b1;
                  mem_addr_q  <= blk_addr(s_tag[victim_d], idx);
                  mem_wdata_q <= s_blk[victim_d];
                  state_q     <= S_WRITEBACK;
               end else begin
                  mem_rw_q   <= 1'b0;
                  mem_addr_q <= blk_addr(tag, idx);
                  state_q    <= S_ALLOCATE;
               end
            end
            S_WRITEBACK: if (mem_ready) begin
               mem_req_q <= 1'b0;
               state_q   <= S_ALLOCATE;
            end
            // Entered with req low after a write-back: raise the refill one cycle later.
            S_ALLOCATE: if (!mem_req_q) begin
               mem_req_q  <= 1'b1;
               mem_rw_q   <= 1'b0;
               mem_addr_q <= blk_addr(tag, idx);
            end else if (mem_ready) begin
               mem_req_q <= 1'b0;
               state_q   <= S_COMPARE;
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cpu_ready = cpu_ready_q;
   assign cpu_hit   = cpu_hit_q;
   assign cpu_rdata = cpu_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_rw    = mem_rw_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: a transaction-level cache model predicts
// every memory transaction and CPU completion; one monitor compares per cycle.
module tb_cache_controller;
   typedef struct {
      logic         rw;
      logic [9:0]   addr;
      logic [127:0] wdata;
   } mtx_t;

   typedef struct {
      logic        hit;
      logic        rw;
      logic [31:0] rdata;
   } cexp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         cpu_req, cpu_rw;
   logic [9:0]   cpu_addr;
   logic [31:0]  cpu_wdata;
   logic         cpu_ready, cpu_hit;
   logic [31:0]  cpu_rdata;
   logic         mem_req, mem_rw;
   logic [9:0]   mem_addr;
   logic [127:0] mem_wdata, mem_rdata;
   logic         mem_ready;

   int n_checks = 0;
   int n_errors = 0;
   int lat = 1;

   mtx_t  mem_q[$];
   mtx_t  log_q[$];
   cexp_t cpu_q[$];

   logic         m_valid [2][2];
   logic         m_dirty [2][2];
   logic [4:0]   m_tag   [2][2];
   logic [127:0] m_data  [2][2];
   logic         m_lru   [2];
   logic [127:0] mem     [64];

   always #5 clk = ~clk;

   cache_controller dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_rw    (cpu_rw),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ready (cpu_ready),
      .cpu_hit   (cpu_hit),
      .cpu_rdata (cpu_rdata),
      .mem_req   (mem_req),
      .mem_rw    (mem_rw),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_lru[s] = 1'b0;
         for (int k = 0; k < 2; k++) begin
            m_valid[s][k] = 1'b0;
            m_dirty[s][k] = 1'b0;
            m_tag[s][k]   = '0;
            m_data[s][k]  = '0;
         end
      end
   endtask

   // Predict one CPU access: queue the memory transactions it must cause and its result.
   task automatic model_op(input logic rw, input logic [9:0] a, input logic [31:0] wd);
      int s, w;
      logic [4:0] tg;
      logic hit, way;
      mtx_t t;
      cexp_t ce;
      s = int'(a[4]);
      w = int'(a[3:2]);
      tg = a[9:5];
      hit = 1'b0;
      way = 1'b0;
      for (int k = 0; k < 2; k++)
         if (m_valid[s][k] && m_tag[s][k] == tg) begin
            hit = 1'b1;
            way = k[0];
         end
      if (!hit) begin
         if (!m_valid[s][0])      way = 1'b0;
         else if (!m_valid[s][1]) way = 1'b1;
         else                     way = m_lru[s];
         if (m_valid[s][way] && m_dirty[s][way]) begin
            t.rw = 1'b1;
            t.addr = {m_tag[s][way], a[4], 4'h0};
            t.wdata = m_data[s][way];
            mem_q.push_back(t);
            mem[{m_tag[s][way], a[4]}] = m_data[s][way];
         end
         t.rw = 1'b0;
         t.addr = {tg, a[4], 4'h0};
         t.wdata = '0;
         mem_q.push_back(t);
         m_data[s][way]  = mem[{tg, a[4]}];
         m_valid[s][way] = 1'b1;
         m_dirty[s][way] = 1'b0;
         m_tag[s][way]   = tg;
      end
      ce.hit = hit;
      ce.rw = rw;
      ce.rdata = m_data[s][way][w*32 +: 32];
      if (rw) begin
         m_data[s][way][w*32 +: 32] = wd;
         m_dirty[s][way] = 1'b1;
      end
      m_lru[s] = (way == 1'b0);
      cpu_q.push_back(ce);
   endtask

   task automatic cpu_op(input logic rw, input logic [9:0] a, input logic [31:0] wd,
                         input int lat_i, input bit tog,
                         output logic hit, output logic [31:0] rd, output int ncyc);
      model_op(rw, a, wd);
      lat = lat_i;
      log_q.delete();
      @(negedge clk);
      cpu_req = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_wdata = wd;
      @(posedge clk);
      ncyc = 0;
      forever begin
         @(negedge clk);
         cpu_req = 1'b0;
         if (tog) begin
            cpu_addr = ~cpu_addr; cpu_wdata = ~cpu_wdata; cpu_rw = ~cpu_rw;
         end
         @(posedge clk); #1;
         ncyc++;
         if (cpu_ready) break;
         if (ncyc > 300) begin
            chk("cpu_ready timeout", {127'b0, cpu_ready}, 1);
            break;
         end
      end
      hit = cpu_hit;
      rd = cpu_rdata;
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      mem_q.delete(); cpu_q.delete(); log_q.delete();
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Memory responder: mem_ready after 'lat' cycles of mem_req, data from the block array.
   initial begin : responder
      int cnt;
      cnt = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      for (int b = 0; b < 64; b++)
         for (int w = 0; w < 4; w++)
            mem[b][w*32 +: 32] = w * 32'h11111111 + b * 32'h00010000;
      forever begin
         @(negedge clk);
         if (mem_req && !rst) begin
            cnt++;
            mem_rdata = mem[mem_addr[9:4]];
            mem_ready = (cnt >= lat);
         end else begin
            cnt = 0;
            mem_ready = 1'b0;
         end
      end
   end

   initial begin : compare
      logic p_req, p_rw;
      logic [9:0] p_addr;
      logic [127:0] p_wd;
      mtx_t t;
      cexp_t ce;
      p_req = 1'b0; p_rw = 1'b0; p_addr = '0; p_wd = '0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            p_req = 1'b0;
            continue;
         end
         if (p_req && mem_ready) begin
            t.rw = p_rw; t.addr = p_addr; t.wdata = p_wd;
            log_q.push_back(t);
            if (mem_q.size() != 0) void'(mem_q.pop_front());
            chk("mem_req low after ready", {127'b0, mem_req}, 0);
         end else if (mem_req) begin
            chk("mem txn expected", {127'b0, mem_q.size() != 0}, 1);
            if (mem_q.size() != 0) begin
               chk("mem_rw", {127'b0, mem_rw}, {127'b0, mem_q[0].rw});
               chk("mem_addr", {118'b0, mem_addr}, {118'b0, mem_q[0].addr});
               if (mem_q[0].rw) chk("mem_wdata", mem_wdata, mem_q[0].wdata);
            end
         end
         if (cpu_ready) begin
            chk("cpu_ready expected", {127'b0, cpu_q.size() != 0}, 1);
            chk("mem txns done at ready", mem_q.size(), 0);
            if (cpu_q.size() != 0) begin
               ce = cpu_q.pop_front();
               chk("cpu_hit", {127'b0, cpu_hit}, {127'b0, ce.hit});
               if (!ce.rw) chk("cpu_rdata", {96'b0, cpu_rdata}, {96'b0, ce.rdata});
            end
         end
         p_req = mem_req; p_rw = mem_rw; p_addr = mem_addr; p_wd = mem_wdata;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin : stim
      logic h;
      logic [31:0] rd;
      int nc, nready;
      mtx_t t;
      mtx_t ta;
      rst = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst cpu_ready", {127'b0, cpu_ready}, 0);
      chk("rst cpu_hit", {127'b0, cpu_hit}, 0);
      chk("rst cpu_rdata", {96'b0, cpu_rdata}, 0);
      chk("rst mem_req", {127'b0, mem_req}, 0);
      chk("rst mem_rw", {127'b0, mem_rw}, 0);
      chk("rst mem_addr", {118'b0, mem_addr}, 0);
      chk("rst mem_wdata", mem_wdata, 0);
      rst = 1'b0;

      // Cold read miss, L = 3
      cpu_op(1'b0, 10'h004, 32'h0, 3, 0, h, rd, nc);
      chk("t1 hit", {127'b0, h}, 0);
      chk("t1 rdata", {96'b0, rd}, 128'h11111111);
      chk("t1 txn count", log_q.size(), 1);
      if (log_q.size() > 0) begin
         t = log_q[0];
         chk("t1 refill rw", {127'b0, t.rw}, 0);
         chk("t1 refill addr", {118'b0, t.addr}, 128'h000);
      end
      chk("t1 clean miss cycles", nc, 5);
      cpu_op(1'b0, 10'h004, 32'h0, 3, 0, h, rd, nc);
      chk("t1 rehit", {127'b0, h}, 1);
      chk("t1 hit cycles", nc, 1);
      chk("t1 hit no txn", log_q.size(), 0);

      // Write hit then read back
      cpu_op(1'b1, 10'h008, 32'hDEADBEEF, 3, 0, h, rd, nc);
      chk("t2 write hit", {127'b0, h}, 1);
      chk("t2 no txn", log_q.size(), 0);
      cpu_op(1'b0, 10'h008, 32'h0, 3, 0, h, rd, nc);
      chk("t2 readback", {96'b0, rd}, 128'hDEADBEEF);

      // Fill way1, then evict dirty way0
      cpu_op(1'b0, 10'h020, 32'h0, 2, 0, h, rd, nc);
      chk("t3 way1 miss", {127'b0, h}, 0);
      chk("t3 clean miss cycles", nc, 4);
      cpu_op(1'b0, 10'h040, 32'h0, 2, 0, h, rd, nc);
      chk("t3 dirty miss hit", {127'b0, h}, 0);
      chk("t3 txn count", log_q.size(), 2);
      if (log_q.size() > 1) begin
         t = log_q[0];
         ta = log_q[1];
         chk("t3 wb rw", {127'b0, t.rw}, 1);
         chk("t3 wb addr", {118'b0, t.addr}, 128'h000);
         chk("t3 wb word2", {96'b0, t.wdata[95:64]}, 128'hDEADBEEF);
         chk("t3 refill addr", {118'b0, ta.addr}, 128'h040);
      end

      // Clean LRU eviction
      do_reset();
      cpu_op(1'b0, 10'h000, 32'h0, 1, 0, h, rd, nc);
      cpu_op(1'b0, 10'h020, 32'h0, 1, 0, h, rd, nc);
      cpu_op(1'b0, 10'h000, 32'h0, 1, 0, h, rd, nc);
      chk("t4 tag0 hit", {127'b0, h}, 1);
      cpu_op(1'b0, 10'h040, 32'h0, 1, 0, h, rd, nc);
      chk("t4 evict hit", {127'b0, h}, 0);
      chk("t4 no wb", log_q.size(), 1);
      if (log_q.size() > 0) begin
         t = log_q[0];
         chk("t4 refill addr", {118'b0, t.addr}, 128'h040);
      end
      cpu_op(1'b0, 10'h000, 32'h0, 1, 0, h, rd, nc);
      chk("t4 tag0 still hit", {127'b0, h}, 1);

      // Write miss in set 1; set 0 untouched
      cpu_op(1'b1, 10'h014, 32'hCAFEF00D, 2, 0, h, rd, nc);
      chk("t5 write miss", {127'b0, h}, 0);
      if (log_q.size() > 0) begin
         t = log_q[0];
         chk("t5 refill addr", {118'b0, t.addr}, 128'h010);
      end
      cpu_op(1'b0, 10'h014, 32'h0, 2, 0, h, rd, nc);
      chk("t5 readback", {96'b0, rd}, 128'hCAFEF00D);
      cpu_op(1'b0, 10'h060, 32'h0, 2, 0, h, rd, nc);
      cpu_op(1'b0, 10'h000, 32'h0, 2, 0, h, rd, nc);
      chk("t5 set0 lru kept", {127'b0, h}, 1);
      cpu_op(1'b0, 10'h034, 32'h0, 2, 0, h, rd, nc);
      cpu_op(1'b0, 10'h054, 32'h0, 2, 0, h, rd, nc);
      if (log_q.size() > 0) begin
         t = log_q[0];
         chk("t5 wb addr", {118'b0, t.addr}, 128'h010);
         chk("t5 wb word1", {96'b0, t.wdata[63:32]}, 128'hCAFEF00D);
      end

      // cpu_req held high: one acceptance per pass through IDLE
      model_op(1'b0, 10'h000, 32'h0);
      model_op(1'b0, 10'h000, 32'h0);
      lat = 1;
      nready = 0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 10'h000;
      repeat (6) begin
         @(posedge clk); #1;
         if (cpu_ready) nready++;
      end
      @(negedge clk);
      cpu_req = 1'b0;
      repeat (2) @(posedge clk);
      chk("held req ready pulses", nready, 2);

      // Slow memory with toggling CPU inputs
      cpu_op(1'b0, 10'h0A4, 32'h0, 10, 1, h, rd, nc);
      chk("t7 hit", {127'b0, h}, 0);
      chk("t7 cycles", nc, 12);
      if (log_q.size() > 0) begin
         t = log_q[log_q.size()-1];
         chk("t7 refill addr", {118'b0, t.addr}, 128'h0A0);
      end

      // Reset during ALLOCATE
      lat = 1000;
      t.rw = 1'b0; t.addr = 10'h0C0; t.wdata = '0;
      mem_q.push_back(t);
      @(negedge clk);
      cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 10'h0C0;
      @(negedge clk);
      cpu_req = 1'b0;
      for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
      chk("t8 alloc req up", {127'b0, mem_req}, 1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t8 mem_req async drop", {127'b0, mem_req}, 0);
      mem_q.delete(); cpu_q.delete(); log_q.delete();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cpu_op(1'b0, 10'h0C0, 32'h0, 2, 0, h, rd, nc);
      chk("t8 post-reset miss", {127'b0, h}, 0);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
